// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner and {pc, instr} FIFO feeding the decode stage.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] HALT_INSTR = 32'h000f0033,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_addr,
    output logic [11:0]            imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    logic [31:0]      r_memPc    [DEPTH];
    logic [31:0]      r_memInstr [DEPTH];

    logic w_empty;
    logic w_redirect;
    logic w_bypass;
    logic w_deq;
    logic w_fifoDeq;
    logic w_enq;
    logic w_write;
    logic w_isHalt;
    logic w_unused;

    assign w_unused   = &{1'b0, redirect_addr[1:0]};
    assign w_empty    = (r_count == '0);
    assign w_redirect = ce && redirect_valid;
    assign w_isHalt   = (imem_data == HALT_INSTR);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && !r_halted && !w_redirect;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        out_valid = 1'b0;
        out_pc    = 32'd0;
        out_instr = NOP_INSTR;
        if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = r_pc;
            out_instr = imem_data;
        end else if (!w_empty) begin
            out_valid = 1'b1;
            out_pc    = r_memPc[r_rdPtr];
            out_instr = r_memInstr[r_rdPtr];
        end
    end

    // A bypassed fetch consumed by decode is never written and never read from the array.
    assign w_deq     = out_valid && deq_ready;
    assign w_fifoDeq = w_deq && !w_bypass;
    assign w_enq     = !r_halted && ((r_count != FULL_CNT) || w_deq);
    assign w_write   = w_enq && !(w_bypass && w_deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= 32'd0;
            r_rdPtr  <= '0;
            r_wrPtr  <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (ce) begin
            if (redirect_valid) begin
                r_pc     <= {redirect_addr[31:2], 2'b00};
                r_rdPtr  <= '0;
                r_wrPtr  <= '0;
                r_count  <= '0;
                r_halted <= 1'b0;
            end else begin
                if (w_enq) begin
                    if (w_isHalt) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                if (w_write) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_fifoDeq) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                case ({w_write, w_fifoDeq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage needs no reset: out_valid masks anything stale.
    always_ff @(posedge clk) begin
        if (ce && !redirect_valid && w_write) begin
            r_memPc[r_wrPtr]    <= r_pc;
            r_memInstr[r_wrPtr] <= imem_data;
        end
    end

    assign imem_addr = r_pc[13:2];
    assign halted    = r_halted;
    assign count     = r_count;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the fetch PC and drives the asynchronous instruction memory.
- Buffers fetched {pc, instr} pairs in a small FIFO so decode can stall without losing fetches.
- Flushes on a branch redirect from ID or EX.
- Stops fetching after the halt instruction 0x000f0033.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
HALT_INSTR, 32'h000f0033, encoding that stops fetching.
NOP_INSTR, 32'h00000013, bubble presented to decode when no entry is valid.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; asynchronous, active-low.
ce  in  1  clock enable; when low, no state changes (reset still acts).
redirect_valid  in  1  flush and redirect request (branch taken or mispredict revert).
redirect_addr  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
imem_addr  out  12  word address to instruction memory; equals pc[13:2].
imem_data  in  32  instruction memory read data; combinational, valid in the same cycle.
deq_ready  in  1  decode accepts the head entry this cycle.
out_valid  out  1  head entry is valid.
out_pc  out  32  PC of head entry; 0 when out_valid is low.
out_instr  out  32  instruction of head entry; NOP_INSTR when out_valid is low.
halted  out  1  halt instruction has been enqueued; fetching is stopped.
count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0):
  - pc=0, rd_ptr=0, wr_ptr=0, count=0, halted=0.
  - Outputs: out_valid=0, out_pc=0, out_instr=NOP_INSTR, imem_addr=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Per-cycle signals, all combinational, used only when ce=1:
  - enq = !halted && (count<DEPTH || deq).
  - deq = out_valid && deq_ready.
- Enqueue: writes {pc, imem_data} at wr_ptr and advances wr_ptr; pc <= pc+4.
  - pc wraps modulo 2^32.
  - imem_addr wraps modulo 4096 words.
- Dequeue: advances rd_ptr.
  - Pointers wrap modulo DEPTH.
  - count <= count + enq - deq.
- Full with deq in the same cycle: enqueue is permitted and count stays at DEPTH.
- Empty with enq in the same cycle: the new entry appears at the output the next cycle (1-cycle fetch-to-decode latency).
  - Default build has no bypass.
- Halt:
  - If the enqueued imem_data == HALT_INSTR, halted <= 1.
  - The halt instruction is itself enqueued.
  - pc holds at the halt address.
  - No further enqueues occur until a redirect.
- Redirect (redirect_valid=1 with ce=1) has priority over all other events in the cycle:
  - Suppresses that cycle's enq and deq.
  - rd_ptr=wr_ptr=0, count=0.
  - pc <= {redirect_addr[31:2], 2'b00}, halted <= 0.
  - out_valid=0 in the following cycle.
  - The first instruction at the target becomes visible two cycles after the redirect edge: fetched in cycle +1, visible in cycle +2.
- ce=0: pc, pointers, count, halted and FIFO contents all hold. Outputs reflect the held state. Redirect and deq are ignored.
- Outputs are driven from the head register/array entry. out_valid = (count != 0).

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and !halted, out_valid=1, out_pc=pc and out_instr=imem_data combinationally (zero-latency fetch).
  - If deq_ready=1 in that cycle, the entry is consumed without being written: pc advances, count stays 0.
  - A halt detected in bypass still sets halted.
  - In a redirect cycle, bypass output is forced invalid.
- Not defined: behaviour exactly as in Behaviour above, with 1-cycle minimum latency.

Test Plan:
- Reset, then imem returns word index*4 at each address, with deq_ready=1 → out_pc sequence 0,4,8,… starting in cycle 1; out_instr matches; count stays 1.
- deq_ready=0 for 6 cycles after reset → count reaches 4 and saturates; pc=0x10; imem_addr=4. Then deq_ready=1 → entries 0,4,8,0xC emerge in order with no loss or duplication.
- Queue full and deq_ready=1 in the same cycle → enqueue of pc=0x10 is accepted; count stays 4.
- redirect_valid=1, redirect_addr=0x0000_0203 while count=3 → next cycle count=0, out_valid=0, out_instr=0x13; imem_addr=0x80; first entry out_pc=0x200 two cycles after the redirect.
- imem_data=0x000f0033 at pc=0x20 → entry enqueued, halted=1, pc holds at 0x20, no further enqueues. A later redirect to 0x40 clears halted and fetching resumes at 0x40.
- rst_n pulsed low mid-cycle with count=2, then ce=0 for 3 cycles with deq_ready=1:
  - Reset clears outputs immediately, without a clock edge.
  - Subsequent ce=0 cycles leave count and pc unchanged.
